// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: walks the PC through instruction memory and
// queues {pc, inst} pairs in a 2-entry in-order buffer, with redirect and fault handling.
module instruction_fetch_unit #(
    parameter int unsigned MEM_BYTES = 16,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, FAULT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [63:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;

    logic pop;
    logic push;
    logic flush;
    logic end_of_mem;

    assign inst_addr = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_inst  = inst0_q;
    assign out_pc    = pc0_q;
    assign busy      = (state_q == FETCH);
    assign fault     = (state_q == FAULT);

    // Range check in 65 bits so a PC near 2^64 cannot wrap past the limit.
    assign end_of_mem = (({1'b0, pc_q} + 65'd4) > 65'(MEM_BYTES));
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        push    = 1'b0;
        flush   = 1'b0;

        if (state_q != FAULT && redirect_valid) begin
            flush = 1'b1;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d    = redirect_pc;
                state_d = FETCH;
            end else begin
                state_d = FAULT;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = FETCH;
                end
                FETCH: begin
                    if (end_of_mem) begin
                        state_d = DONE;
                    end else if (count_q != 2'd2 || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 64'd4;
                    end
                end
                default: ;
            endcase
        end

        // Slot 0 is always the head; slot 1 holds the younger entry when full.
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_d   = pc_q;
                        inst0_d = inst_data;
                    end else begin
                        pc1_d   = pc_q;
                        inst1_d = inst_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    pc0_d   = pc1_q;
                    inst0_d = inst1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        pc0_d   = pc_q;
                        inst0_d = inst_data;
                    end else begin
                        pc0_d   = pc1_q;
                        inst0_d = inst1_q;
                        pc1_d   = pc_q;
                        inst1_d = inst_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            pc0_q   <= 64'd0;
            pc1_q   <= 64'd0;
            inst0_q <= 32'd0;
            inst1_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a 4-word program image.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] inst_addr;
    logic [31:0] inst_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        busy;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:3];

    instruction_fetch_unit #(.MEM_BYTES(16), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_addr(inst_addr), .inst_data(inst_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    assign inst_data = (inst_addr < 64'd16) ? mem[inst_addr[3:2]] : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        mem[0] = 32'h02853483;
        mem[1] = 32'h009A84B3;
        mem[2] = 32'h00148493;
        mem[3] = 32'h02953423;
        reset_n = 1'b0; start = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 64'h0; out_ready = 1'b0;
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_fault", 64'(fault),     64'd0);
        check("rst_addr",  inst_addr,      64'd0);
        check("rst_inst",  64'(out_inst),  64'd0);
        check("rst_pc",    out_pc,         64'd0);
        step();
        reset_n = 1'b1;

        // Straight run with consumer always ready.
        out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        check("a_busy", 64'(busy), 64'd1);
        check("a_nv",   64'(out_valid), 64'd0);
        step();
        check("a0_v", 64'(out_valid), 64'd1);
        check("a0_pc", out_pc, 64'd0);  check("a0_i", 64'(out_inst), 64'h02853483);
        step();
        check("a1_pc", out_pc, 64'd4);  check("a1_i", 64'(out_inst), 64'h009A84B3);
        step();
        check("a2_pc", out_pc, 64'd8);  check("a2_i", 64'(out_inst), 64'h00148493);
        step();
        check("a3_pc", out_pc, 64'd12); check("a3_i", 64'(out_inst), 64'h02953423);
        step();
        check("a_done_v", 64'(out_valid), 64'd0);
        check("a_done_b", 64'(busy), 64'd0);
        check("a_done_addr", inst_addr, 64'd16);

        // Back-pressure: buffer fills to two, then drains in order.
        do_reset();
        check("b_rst_v", 64'(out_valid), 64'd0);
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step();
        check("b_v", 64'(out_valid), 64'd1);
        step();
        check("b_addr8", inst_addr, 64'd8);
        step();
        check("b_hold_pc", out_pc, 64'd0);
        check("b_hold_addr", inst_addr, 64'd8);
        out_ready = 1'b1;
        step(); check("b1_pc", out_pc, 64'd4);
        step(); check("b2_pc", out_pc, 64'd8);
        step(); check("b3_pc", out_pc, 64'd12);
        check("b3_i", 64'(out_inst), 64'h02953423);
        step(); check("b_end_v", 64'(out_valid), 64'd0);

        // Redirect while the buffer holds pc 0,4.
        do_reset();
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 64'd4;
        step();
        redirect_valid = 1'b0;
        check("c_flush_v", 64'(out_valid), 64'd0);
        check("c_addr", inst_addr, 64'd4);
        out_ready = 1'b1;
        step(); check("c1_pc", out_pc, 64'd4);
        check("c1_i", 64'(out_inst), 64'h009A84B3);
        step(); check("c2_pc", out_pc, 64'd8);

        // Misaligned redirect faults and is sticky.
        redirect_valid = 1'b1; redirect_pc = 64'd6;
        step();
        redirect_valid = 1'b0;
        check("d_fault", 64'(fault), 64'd1);
        check("d_v", 64'(out_valid), 64'd0);
        check("d_busy", 64'(busy), 64'd0);
        check("d_addr", inst_addr, 64'd12);
        redirect_valid = 1'b1; redirect_pc = 64'd0; start = 1'b1;
        step();
        redirect_valid = 1'b0; start = 1'b0;
        check("d_stick_f", 64'(fault), 64'd1);
        check("d_stick_b", 64'(busy), 64'd0);
        check("d_stick_a", inst_addr, 64'd12);
        reset_n = 1'b0; #1;
        check("d_clr", 64'(fault), 64'd0);
        reset_n = 1'b1;

        // Run to DONE, redirect back into the image, then reset mid-run.
        out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (5) step();
        check("e_done_b", 64'(busy), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'd8;
        step();
        redirect_valid = 1'b0;
        check("e_busy", 64'(busy), 64'd1);
        check("e_addr", inst_addr, 64'd8);
        step(); check("e1_pc", out_pc, 64'd8);
        step(); check("e2_pc", out_pc, 64'd12);
        step();
        check("e_done_v", 64'(out_valid), 64'd0);
        check("e_done_b2", 64'(busy), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'd0;
        step();
        redirect_valid = 1'b0;
        step(); check("e3_pc", out_pc, 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check("e_rst_v", 64'(out_valid), 64'd0);
        check("e_rst_a", inst_addr, 64'd0);
        check("e_rst_pc", out_pc, 64'd0);
        reset_n = 1'b1;
        step();
        check("e_idle_b", 64'(busy), 64'd0);
        check("e_idle_v", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
